// File: rtl/cpu_seq_ctrl_if.sv
// Instruction- and data-memory request/acknowledge handshakes of the sequencer.
interface cpu_seq_ctrl_if;
  logic imem_req;
  logic imem_ack;
  logic dmem_req;
  logic dmem_we;
  logic dmem_ack;

  modport master (
    output imem_req, dmem_req, dmem_we,
    input  imem_ack, dmem_ack
  );

  modport slave (
    input  imem_req, dmem_req, dmem_we,
    output imem_ack, dmem_ack
  );
endinterface

// File: rtl/cpu_seq_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the non-pipelined MIPS core,
// with memory-wait timeout, halt-address detection and a retired-instruction counter.
module cpu_seq_ctrl #(
  parameter int HALT_PC_WORD = 3,
  parameter int MEM_TIMEOUT  = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [5:0]            opcode,
  input  logic [31:0]           nxt_pc,
  cpu_seq_ctrl_if.master        mem,
  output logic                  ir_load,
  output logic                  pc_en,
  output logic                  rf_we,
  output logic                  busy,
  output logic                  halted,
  output logic                  err,
  output logic [31:0]           instr_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT, S_ERR
  } state_t;

  typedef enum logic [2:0] {
    OP_ALU, OP_LW, OP_SW, OP_BR, OP_ILL
  } op_t;

  localparam logic [7:0]  TO_LAST   = 8'(MEM_TIMEOUT - 1);
  localparam logic [29:0] HALT_WORD = 30'(HALT_PC_WORD);

  function automatic op_t decode_op(input logic [5:0] opc);
    op_t res;
    case (opc)
      6'h00, 6'h08: res = OP_ALU;
      6'h23:        res = OP_LW;
      6'h2B:        res = OP_SW;
      6'h04, 6'h02: res = OP_BR;
      default:      res = OP_ILL;
    endcase
    return res;
  endfunction

  state_t      state_r, state_nxt_s;
  op_t         op_r;
  logic [7:0]  wait_cnt_r;
  logic        commit_s;
  logic        halt_hit_s;
  logic        ir_load_s;
  logic        unused_s;

  assign halt_hit_s = (nxt_pc[31:2] == HALT_WORD);
  assign unused_s   = ^nxt_pc[1:0];

  // Next-state and commit decode.
  always_comb begin
    state_nxt_s = state_r;
    commit_s    = 1'b0;
    ir_load_s   = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (start) state_nxt_s = S_FETCH;
        else       state_nxt_s = S_IDLE;
      end
      S_FETCH: begin
        if (mem.imem_ack) begin
          ir_load_s   = 1'b1;
          state_nxt_s = S_DECODE;
        end else if (wait_cnt_r == TO_LAST) begin
          state_nxt_s = S_ERR;
        end else begin
          state_nxt_s = S_FETCH;
        end
      end
      S_DECODE: begin
        if (decode_op(opcode) == OP_ILL) state_nxt_s = S_ERR;
        else                             state_nxt_s = S_EXEC;
      end
      S_EXEC: begin
        case (op_r)
          OP_BR:        commit_s    = 1'b1;
          OP_ALU:       state_nxt_s = S_WB;
          OP_LW, OP_SW: state_nxt_s = S_MEM;
          default:      state_nxt_s = S_ERR;
        endcase
      end
      S_MEM: begin
        // An ack in the final allowed wait cycle still completes the access.
        if (mem.dmem_ack) begin
          if (op_r == OP_SW) commit_s    = 1'b1;
          else               state_nxt_s = S_WB;
        end else if (wait_cnt_r == TO_LAST) begin
          state_nxt_s = S_ERR;
        end else begin
          state_nxt_s = S_MEM;
        end
      end
      S_WB:    commit_s    = 1'b1;
      S_HALT:  state_nxt_s = S_HALT;
      S_ERR:   state_nxt_s = S_ERR;
      default: state_nxt_s = S_ERR;
    endcase
    if (commit_s) begin
      if (halt_hit_s) state_nxt_s = S_HALT;
      else            state_nxt_s = S_FETCH;
    end else begin
      state_nxt_s = state_nxt_s;
    end
  end

  // State, latched opcode class, wait counter and retired-instruction count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= S_IDLE;
      op_r        <= OP_ALU;
      wait_cnt_r  <= 8'd0;
      instr_count <= 32'd0;
    end else begin
      state_r <= state_nxt_s;
      if (state_r == S_DECODE) op_r <= decode_op(opcode);
      if (state_nxt_s != state_r)
        wait_cnt_r <= 8'd0;
      else if ((state_r == S_FETCH && !mem.imem_ack) || (state_r == S_MEM && !mem.dmem_ack))
        wait_cnt_r <= wait_cnt_r + 8'd1;
      if (commit_s) instr_count <= instr_count + 32'd1;
    end
  end

  assign mem.imem_req = (state_r == S_FETCH);
  assign mem.dmem_req = (state_r == S_MEM);
  assign mem.dmem_we  = (state_r == S_MEM) && (op_r == OP_SW);

  // Pulses are masked while reset is asserted so a colliding ack cannot commit.
  assign ir_load = ir_load_s & rst_n;
  assign pc_en   = commit_s & ~halt_hit_s & rst_n;
  assign rf_we   = (state_r == S_WB) & rst_n;

  assign busy   = (state_r == S_FETCH) || (state_r == S_DECODE) || (state_r == S_EXEC) ||
                  (state_r == S_MEM)   || (state_r == S_WB);
  assign halted = (state_r == S_HALT);
  assign err    = (state_r == S_ERR);

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// Self-checking bench for cpu_seq_ctrl: instruction table with a scoreboard of
// expected commit behaviour, plus hand sequences for halt, timeout, illegal opcode and reset.
module tb_cpu_seq_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [5:0]  opcode;
  logic [31:0] nxt_pc;
  logic        ir_load, pc_en, rf_we, busy, halted, err;
  logic [31:0] instr_count;

  cpu_seq_ctrl_if mem_if ();

  cpu_seq_ctrl #(.HALT_PC_WORD(3), .MEM_TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode), .nxt_pc(nxt_pc),
    .mem(mem_if), .ir_load(ir_load), .pc_en(pc_en), .rf_we(rf_we),
    .busy(busy), .halted(halted), .err(err), .instr_count(instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  opc;
    int          iw;
    int          dw;
    logic [31:0] npc;
    int          cyc;
    int          rf;
    int          dreq;
    logic        we;
  } vec_t;

  typedef struct {
    int          cyc;
    int          rf;
    int          dreq;
    logic        we;
    logic [31:0] cnt;
  } exp_t;

  vec_t vecs[10];
  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    start = 1'b0;
    mem_if.imem_ack = 1'b0;
    mem_if.dmem_ack = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  function automatic logic [9:0] out_bits();
    return {mem_if.imem_req, mem_if.dmem_req, mem_if.dmem_we, ir_load, pc_en, rf_we,
            busy, halted, err, |instr_count};
  endfunction

  // Entered at the first FETCH cycle; leaves at the next instruction's first cycle.
  task automatic run_instr(input vec_t v, input logic [31:0] exp_cnt);
    exp_t e, got;
    int   t, icnt, dcnt, rfc, ldc, dreqc;
    logic wes, done;
    e = '{v.cyc, v.rf, v.dreq, v.we, exp_cnt};
    sb.push_back(e);
    opcode = v.opc;
    nxt_pc = v.npc;
    t = 0; icnt = 0; dcnt = 0; rfc = 0; ldc = 0; dreqc = 0; wes = 1'b0; done = 1'b0;
    while (!done && t < 60) begin
      t++;
      mem_if.imem_ack = mem_if.imem_req && (icnt == v.iw);
      mem_if.dmem_ack = mem_if.dmem_req && (dcnt == v.dw);
      @(negedge clk);
      if (mem_if.imem_req) icnt++;
      if (mem_if.dmem_req) begin
        dcnt++;
        dreqc++;
        if (mem_if.dmem_we) wes = 1'b1;
      end
      if (rf_we)   rfc++;
      if (ir_load) ldc++;
      if (pc_en)   done = 1'b1;
      tick();
    end
    mem_if.imem_ack = 1'b0;
    mem_if.dmem_ack = 1'b0;
    check("commit_seen", {31'd0, done}, 32'd1);
    if (sb.size() == 0) begin
      check("scoreboard_empty", 32'd0, 32'd1);
    end else begin
      got = sb.pop_front();
      check("latency", t, got.cyc);
      check("rf_we_pulses", rfc, got.rf);
      check("dmem_req_cycles", dreqc, got.dreq);
      check("dmem_we", {31'd0, wes}, {31'd0, got.we});
      check("ir_load_pulses", ldc, 32'd1);
      check("instr_count", instr_count, got.cnt);
      check("refetch_req", {31'd0, mem_if.imem_req}, 32'd1);
      check("no_err", {31'd0, err}, 32'd0);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   rq, bad, pcs;
    rst_n = 1'b0;
    start = 1'b0;
    opcode = 6'h00;
    nxt_pc = 32'h0000_0100;
    mem_if.imem_ack = 1'b0;
    mem_if.dmem_ack = 1'b0;

    //              opc    iw  dw  nxt_pc          cyc rf dreq we
    vecs[0] = '{6'h00,  0,  0, 32'h0000_0104,  4, 1,  0, 1'b0};
    vecs[1] = '{6'h23,  0,  0, 32'h0000_0108,  5, 1,  1, 1'b0};
    vecs[2] = '{6'h2B,  0,  0, 32'h0000_010C,  4, 0,  1, 1'b1};
    vecs[3] = '{6'h04,  0,  0, 32'h0000_0200,  3, 0,  0, 1'b0};
    vecs[4] = '{6'h02,  0,  0, 32'h0000_0400,  3, 0,  0, 1'b0};
    vecs[5] = '{6'h08,  2,  0, 32'h0000_0404,  6, 1,  0, 1'b0};
    vecs[6] = '{6'h23,  0,  3, 32'h0000_0408,  8, 1,  4, 1'b0};
    vecs[7] = '{6'h2B,  1,  2, 32'h0000_040C,  7, 0,  3, 1'b1};
    vecs[8] = '{6'h00, 14,  0, 32'h0000_0410, 18, 1,  0, 1'b0};
    vecs[9] = '{6'h23,  0, 14, 32'h0000_0414, 19, 1, 15, 1'b0};

    do_reset();
    @(negedge clk);
    check("reset_outputs", {22'd0, out_bits()}, 32'd0);

    // Acks while the requests are low must not move the sequencer.
    tick();
    mem_if.imem_ack = 1'b1;
    mem_if.dmem_ack = 1'b1;
    tick();
    tick();
    mem_if.imem_ack = 1'b0;
    mem_if.dmem_ack = 1'b0;
    check("idle_ack_ignored", {22'd0, out_bits()}, 32'd0);

    do_start();
    check("start_to_imem_req", {31'd0, mem_if.imem_req}, 32'd1);
    check("busy_in_fetch", {31'd0, busy}, 32'd1);

    for (int i = 0; i < 10; i++) run_instr(vecs[i], 32'(i + 1));

    // Halt: jump whose next PC is word 3.
    opcode = 6'h02;
    nxt_pc = 32'h0000_000C;
    mem_if.imem_ack = 1'b1;
    pcs = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (pc_en) pcs++;
      tick();
      mem_if.imem_ack = 1'b0;
    end
    check("halt_no_pc_en", pcs, 32'd0);
    check("halted", {31'd0, halted}, 32'd1);
    check("halt_busy", {31'd0, busy}, 32'd0);
    check("halt_count", instr_count, 32'd11);
    start = 1'b1;
    bad = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (!halted || busy || mem_if.imem_req || pc_en || err) bad++;
      tick();
    end
    start = 1'b0;
    check("halt_sticky", bad, 32'd0);

    // Fetch timeout.
    do_reset();
    do_start();
    rq = 0;
    while (!err && rq < 40) begin
      @(negedge clk);
      if (mem_if.imem_req) rq++;
      tick();
    end
    check("timeout_req_cycles", rq, 32'd15);
    @(negedge clk);
    check("timeout_err", {29'd0, err, busy, mem_if.imem_req}, 32'd4);
    tick();
    start = 1'b1;
    for (int c = 0; c < 5; c++) tick();
    start = 1'b0;
    @(negedge clk);
    check("err_sticky_vs_start", {29'd0, err, busy, mem_if.imem_req}, 32'd4);
    check("timeout_count", instr_count, 32'd0);

    // Illegal opcode.
    do_reset();
    do_start();
    opcode = 6'h3F;
    mem_if.imem_ack = 1'b1;
    bad = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (pc_en || rf_we) bad++;
      tick();
      mem_if.imem_ack = 1'b0;
    end
    check("illegal_no_pulses", bad, 32'd0);
    check("illegal_err", {30'd0, err, busy}, 32'd2);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_from_err", {22'd0, out_bits()}, 32'd0);

    // Reset colliding with a store's dmem_ack.
    tick();
    opcode = 6'h2B;
    nxt_pc = 32'h0000_0100;
    do_start();
    mem_if.imem_ack = 1'b1;
    tick();
    mem_if.imem_ack = 1'b0;
    tick();
    tick();
    check("mem_req_before_reset", {30'd0, mem_if.dmem_req, mem_if.dmem_we}, 32'd3);
    rst_n = 1'b0;
    mem_if.dmem_ack = 1'b1;
    @(negedge clk);
    check("reset_masks_pc_en", {31'd0, pc_en}, 32'd0);
    tick();
    rst_n = 1'b1;
    mem_if.dmem_ack = 1'b0;
    @(negedge clk);
    check("reset_drops_dmem_req", {31'd0, mem_if.dmem_req}, 32'd0);
    check("reset_count_zero", instr_count, 32'd0);
    check("reset_idle", {22'd0, out_bits()}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
